// File: rtl/rdmap_pkg.sv
// Shared definitions for the RDMAP transmit header path: opcodes, header field
// positions, source indices and a SEND/TID header builder.
package rdmap_pkg;

  localparam int unsigned TID_W   = 8;
  localparam int unsigned QN_W    = 16;
  localparam int unsigned HDR_W   = 48;
  localparam int unsigned SEG_W   = 3;
  localparam int unsigned NUM_SRC = 5;

  // 4-bit RDMAP opcodes, shared with the receive-side classifier
  localparam logic [3:0] OP_SEND    = 4'b0000;
  localparam logic [3:0] OP_RCV     = 4'b0001;
  localparam logic [3:0] OP_REQ     = 4'b0011;
  localparam logic [3:0] OP_ACK     = 4'b0111;
  localparam logic [3:0] OP_WR_DONE = 4'b0110;
  localparam logic [3:0] OP_RD_DONE = 4'b0100;

  // Header field LSB positions
  localparam int unsigned HDR_TID_LSB  = 40;
  localparam int unsigned HDR_SEG_LSB  = 37;
  localparam int unsigned HDR_LAST_BIT = 36;
  localparam int unsigned ACK_TID_LSB  = 36;
  localparam int unsigned ACK_QN_LSB   = 20;

  // Source index; also the round-robin order
  typedef enum logic [2:0] {
    SrcAck    = 3'd0,
    SrcReq    = 3'd1,
    SrcSend   = 3'd2,
    SrcWrDone = 3'd3,
    SrcRdDone = 3'd4
  } src_e;

  // TID in [47:40], segment index and last flag; WR_DONE/RD_DONE use seg=0, last=0
  function automatic logic [HDR_W-1:0] send_hdr(input logic [TID_W-1:0] tid,
                                                input logic [SEG_W-1:0] seg,
                                                input logic             last);
    logic [HDR_W-1:0] h;
    h = '0;
    h[HDR_TID_LSB +: TID_W] = tid;
    h[HDR_SEG_LSB +: SEG_W] = seg;
    h[HDR_LAST_BIT]         = last;
    return h;
  endfunction

endpackage

// File: rtl/rdmap_rr_arb.sv
// Five-way round-robin arbiter. The grant is combinational and one-hot; the
// pointer moves past the given source only when the advance strobe fires.
module rdmap_rr_arb
  import rdmap_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_SRC-1:0] i_req,
  input  logic               i_advance,
  input  src_e               i_adv_src,
  output logic [NUM_SRC-1:0] o_gnt,
  output src_e               o_gnt_src
);

  src_e r_ptr;
  src_e w_ptr_next;

  // Pick the first requester at or after the pointer, wrapping at NUM_SRC
  always_comb begin
    logic        found;
    int unsigned idx;
    o_gnt     = '0;
    o_gnt_src = SrcAck;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < NUM_SRC; off++) begin
      idx = (32'(r_ptr) + off) % NUM_SRC;
      if (!found && i_req[idx]) begin
        found      = 1'b1;
        o_gnt[idx] = 1'b1;
        o_gnt_src  = src_e'(idx[2:0]);
      end
    end
  end

  assign w_ptr_next = (i_adv_src == SrcRdDone) ? SrcAck : src_e'(i_adv_src + 3'd1);

  // Pointer register: starts at ACK, steps past the source just finished
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= SrcAck;
    end else if (i_advance) begin
      r_ptr <= w_ptr_next;
    end
  end

endmodule

// File: rtl/rdmap_hdr_gen.sv
// Transmit-side RDMAP header generator: arbitrates the five operator FIFOs,
// builds one header per segment and hands it to DDP over valid/ready.
module rdmap_hdr_gen
  import rdmap_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    sendFifoEmpty,
  output logic                    sendFifoPop,
  input  logic [SEG_W+TID_W-1:0]  sendFifoData,
  input  logic                    ackFifoEmpty,
  output logic                    ackFifoPop,
  input  logic [TID_W+QN_W-1:0]   ackFifoData,
  input  logic                    wrDoneFifoEmpty,
  output logic                    wrDoneFifoPop,
  input  logic [TID_W-1:0]        wrDoneFifoData,
  input  logic                    rdDoneFifoEmpty,
  output logic                    rdDoneFifoPop,
  input  logic [TID_W-1:0]        rdDoneFifoData,
  input  logic                    reqFifoEmpty,
  output logic                    reqFifoPop,
  input  logic [HDR_W-1:0]        reqFifoData,
  output logic                    dataNumWr,
  output logic [TID_W-1:0]        dataNumWrAddr,
  output logic [SEG_W-1:0]        dataNumWrData,
  output logic                    rdmap2DdpHdrValid,
  output logic [7:0]              rdmap2DdpControl,
  output logic [HDR_W-1:0]        rdmap2DdpHeader,
  input  logic                    ddp2RdmapHdrReady,
  output logic                    errDataNum,
  output logic                    busy
);

  typedef enum logic {StIdle, StEmit} state_e;

  state_e           r_state, w_state_d;
  src_e             r_src, w_src_d;
  logic [HDR_W-1:0] r_hdr, w_hdr_d;
  logic [3:0]       r_op, w_op_d;
  logic [SEG_W-1:0] r_seg, w_seg_d;
  logic [SEG_W-1:0] r_total, w_total_d;
  logic [TID_W-1:0] r_tid, w_tid_d;

  logic [NUM_SRC-1:0] w_req, w_gnt, w_pop;
  src_e               w_gnt_src;
  logic               w_can_grant, w_grant, w_accept, w_last, w_advance;
  logic [SEG_W-1:0]   w_dn_raw, w_dn, w_seg_next;

  assign w_req = {~rdDoneFifoEmpty, ~wrDoneFifoEmpty, ~sendFifoEmpty,
                  ~reqFifoEmpty, ~ackFifoEmpty};

  rdmap_rr_arb u_arb (
    .i_clk     (clock),
    .i_rst_n   (reset),
    .i_req     (w_req),
    .i_advance (w_advance),
    .i_adv_src (r_src),
    .o_gnt     (w_gnt),
    .o_gnt_src (w_gnt_src)
  );

  // Reset also gates the combinational strobes so every output reads 0 while held
  assign w_can_grant = (r_state == StIdle) && reset;
  assign w_pop       = w_can_grant ? w_gnt : '0;
  assign w_grant     = |w_pop;

  // A zero segment count is flagged and treated as one segment
  assign w_dn_raw = sendFifoData[TID_W +: SEG_W];
  assign w_dn     = (w_dn_raw == '0) ? SEG_W'(1) : w_dn_raw;

  assign w_accept   = (r_state == StEmit) && ddp2RdmapHdrReady;
  assign w_last     = (r_src != SrcSend) || (r_seg == r_total - SEG_W'(1));
  assign w_advance  = w_accept && w_last;
  assign w_seg_next = r_seg + SEG_W'(1);

  // Next-state: latch the granted message in IDLE, step segments in EMIT
  always_comb begin
    w_state_d = r_state;
    w_src_d   = r_src;
    w_hdr_d   = r_hdr;
    w_op_d    = r_op;
    w_seg_d   = r_seg;
    w_total_d = r_total;
    w_tid_d   = r_tid;
    unique case (r_state)
      StIdle: begin
        if (w_grant) begin
          w_state_d = StEmit;
          w_src_d   = w_gnt_src;
          w_seg_d   = '0;
          w_total_d = SEG_W'(1);
          unique case (w_gnt_src)
            SrcAck: begin
              w_op_d  = OP_ACK;
              w_hdr_d = '0;
              w_hdr_d[ACK_TID_LSB +: TID_W] = ackFifoData[QN_W +: TID_W];
              w_hdr_d[ACK_QN_LSB +: QN_W]   = ackFifoData[QN_W-1:0];
            end
            SrcReq: begin
              w_op_d  = OP_REQ;
              w_hdr_d = reqFifoData;
            end
            SrcSend: begin
              w_op_d    = OP_SEND;
              w_tid_d   = sendFifoData[TID_W-1:0];
              w_total_d = w_dn;
              w_hdr_d   = send_hdr(sendFifoData[TID_W-1:0], '0, w_dn == SEG_W'(1));
            end
            SrcWrDone: begin
              w_op_d  = OP_WR_DONE;
              w_hdr_d = send_hdr(wrDoneFifoData, '0, 1'b0);
            end
            SrcRdDone: begin
              w_op_d  = OP_RD_DONE;
              w_hdr_d = send_hdr(rdDoneFifoData, '0, 1'b0);
            end
            default: ;
          endcase
        end
      end
      StEmit: begin
        if (w_accept) begin
          if (w_last) begin
            w_state_d = StIdle;
          end else begin
            w_seg_d = w_seg_next;
            w_hdr_d = send_hdr(r_tid, w_seg_next, w_seg_next == r_total - SEG_W'(1));
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and header registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_src   <= SrcAck;
      r_hdr   <= '0;
      r_op    <= '0;
      r_seg   <= '0;
      r_total <= '0;
      r_tid   <= '0;
    end else begin
      r_state <= w_state_d;
      r_src   <= w_src_d;
      r_hdr   <= w_hdr_d;
      r_op    <= w_op_d;
      r_seg   <= w_seg_d;
      r_total <= w_total_d;
      r_tid   <= w_tid_d;
    end
  end

  assign ackFifoPop    = w_pop[SrcAck];
  assign reqFifoPop    = w_pop[SrcReq];
  assign sendFifoPop   = w_pop[SrcSend];
  assign wrDoneFifoPop = w_pop[SrcWrDone];
  assign rdDoneFifoPop = w_pop[SrcRdDone];

  assign dataNumWr     = w_pop[SrcSend];
  assign dataNumWrAddr = dataNumWr ? sendFifoData[TID_W-1:0] : '0;
  assign dataNumWrData = dataNumWr ? w_dn : '0;
  assign errDataNum    = dataNumWr && (w_dn_raw == '0);

  assign rdmap2DdpHdrValid = (r_state == StEmit);
  assign busy              = (r_state == StEmit);
  assign rdmap2DdpControl  = {4'b0000, r_op};
  assign rdmap2DdpHeader   = r_hdr;

endmodule

// File: tb/tb_rdmap_hdr_gen.sv
// Directed self-checking bench for rdmap_hdr_gen. FIFOs are modelled as an
// entry count plus constant show-ahead data per source.
module tb_rdmap_hdr_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic        sendFifoEmpty, sendFifoPop;
  logic [10:0] sendFifoData;
  logic        ackFifoEmpty, ackFifoPop;
  logic [23:0] ackFifoData;
  logic        wrDoneFifoEmpty, wrDoneFifoPop;
  logic [7:0]  wrDoneFifoData;
  logic        rdDoneFifoEmpty, rdDoneFifoPop;
  logic [7:0]  rdDoneFifoData;
  logic        reqFifoEmpty, reqFifoPop;
  logic [47:0] reqFifoData;
  logic        dataNumWr;
  logic [7:0]  dataNumWrAddr;
  logic [2:0]  dataNumWrData;
  logic        rdmap2DdpHdrValid;
  logic [7:0]  rdmap2DdpControl;
  logic [47:0] rdmap2DdpHeader;
  logic        ddp2RdmapHdrReady;
  logic        errDataNum;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int cnt[5];
  logic [7:0] exp_ctrl[5];

  always #5 clock = ~clock;

  rdmap_hdr_gen dut (
    .clock             (clock),
    .reset             (reset),
    .sendFifoEmpty     (sendFifoEmpty),
    .sendFifoPop       (sendFifoPop),
    .sendFifoData      (sendFifoData),
    .ackFifoEmpty      (ackFifoEmpty),
    .ackFifoPop        (ackFifoPop),
    .ackFifoData       (ackFifoData),
    .wrDoneFifoEmpty   (wrDoneFifoEmpty),
    .wrDoneFifoPop     (wrDoneFifoPop),
    .wrDoneFifoData    (wrDoneFifoData),
    .rdDoneFifoEmpty   (rdDoneFifoEmpty),
    .rdDoneFifoPop     (rdDoneFifoPop),
    .rdDoneFifoData    (rdDoneFifoData),
    .reqFifoEmpty      (reqFifoEmpty),
    .reqFifoPop        (reqFifoPop),
    .reqFifoData       (reqFifoData),
    .dataNumWr         (dataNumWr),
    .dataNumWrAddr     (dataNumWrAddr),
    .dataNumWrData     (dataNumWrData),
    .rdmap2DdpHdrValid (rdmap2DdpHdrValid),
    .rdmap2DdpControl  (rdmap2DdpControl),
    .rdmap2DdpHeader   (rdmap2DdpHeader),
    .ddp2RdmapHdrReady (ddp2RdmapHdrReady),
    .errDataNum        (errDataNum),
    .busy              (busy)
  );

  function automatic logic [4:0] pops();
    return {rdDoneFifoPop, wrDoneFifoPop, sendFifoPop, reqFifoPop, ackFifoPop};
  endfunction

  task automatic drive_fifos();
    ackFifoEmpty    = (cnt[0] == 0);
    reqFifoEmpty    = (cnt[1] == 0);
    sendFifoEmpty   = (cnt[2] == 0);
    wrDoneFifoEmpty = (cnt[3] == 0);
    rdDoneFifoEmpty = (cnt[4] == 0);
    #1;
  endtask

  // One clock: remember pops, retire popped entries at the edge, settle after negedge
  task automatic step();
    logic [4:0] p;
    p = pops();
    @(posedge clock);
    for (int i = 0; i < 5; i++) if (p[i] && cnt[i] > 0) cnt[i]--;
    @(negedge clock);
    drive_fifos();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ddp2RdmapHdrReady = 1'b1;
    for (int i = 0; i < 5; i++) cnt[i] = 1;
    sendFifoData = {3'd0, 8'h55};
    @(negedge clock);
    drive_fifos();
    n_cmp++; if (pops() !== 5'b0) begin n_err++; $display("FAIL rst_pops: got %b want 00000", pops()); end
    n_cmp++; if (dataNumWr !== 1'b0 || errDataNum !== 1'b0) begin n_err++; $display("FAIL rst_dnwr: got wr=%b err=%b want 0 0", dataNumWr, errDataNum); end
    n_cmp++; if (dataNumWrAddr !== 8'h0 || dataNumWrData !== 3'd0) begin n_err++; $display("FAIL rst_dnbus: got %h/%h want 0/0", dataNumWrAddr, dataNumWrData); end
    n_cmp++; if (rdmap2DdpHdrValid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_valid: got v=%b busy=%b want 0 0", rdmap2DdpHdrValid, busy); end
    n_cmp++; if (rdmap2DdpHeader !== 48'h0 || rdmap2DdpControl !== 8'h0) begin n_err++; $display("FAIL rst_hdr: got %h/%h want 0/0", rdmap2DdpHeader, rdmap2DdpControl); end
    step();
    for (int i = 0; i < 5; i++) cnt[i] = 0;
    drive_fifos();
    reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || pops() !== 5'b0) begin n_err++; $display("FAIL rst_release: got busy=%b pops=%b want 0 00000", busy, pops()); end
    step();
  endtask

  task automatic test_ack();
    cnt[0] = 1;
    ackFifoData = {8'h3C, 16'hBEEF};
    drive_fifos();
    n_cmp++; if (pops() !== 5'b00001) begin n_err++; $display("FAIL ack_pop: got %b want 00001", pops()); end
    n_cmp++; if (rdmap2DdpHdrValid !== 1'b0) begin n_err++; $display("FAIL ack_valid_n: got %b want 0", rdmap2DdpHdrValid); end
    step();
    n_cmp++; if (rdmap2DdpHdrValid !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL ack_valid: got v=%b busy=%b want 1 1", rdmap2DdpHdrValid, busy); end
    n_cmp++; if (rdmap2DdpControl !== 8'h07) begin n_err++; $display("FAIL ack_ctrl: got %h want 07", rdmap2DdpControl); end
    n_cmp++; if (rdmap2DdpHeader !== 48'h03CBEEF00000) begin n_err++; $display("FAIL ack_hdr: got %h want 03cbeef00000", rdmap2DdpHeader); end
    n_cmp++; if (pops() !== 5'b0) begin n_err++; $display("FAIL ack_nopop: got %b want 00000", pops()); end
    step();
    n_cmp++; if (rdmap2DdpHdrValid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL ack_end: got v=%b busy=%b want 0 0", rdmap2DdpHdrValid, busy); end
  endtask

  task automatic test_send();
    logic [2:0]  sg;
    logic [47:0] exp;
    cnt[2] = 1;
    sendFifoData = {3'd3, 8'h11};
    drive_fifos();
    n_cmp++; if (pops() !== 5'b00100) begin n_err++; $display("FAIL send_pop: got %b want 00100", pops()); end
    n_cmp++; if (dataNumWr !== 1'b1 || dataNumWrAddr !== 8'h11 || dataNumWrData !== 3'd3) begin n_err++; $display("FAIL send_dnwr: got %b/%h/%0d want 1/11/3", dataNumWr, dataNumWrAddr, dataNumWrData); end
    n_cmp++; if (errDataNum !== 1'b0) begin n_err++; $display("FAIL send_err: got %b want 0", errDataNum); end
    step();
    for (int s = 0; s < 3; s++) begin
      sg = 3'(s);
      exp = {8'h11, sg, (s == 2), 36'h0};
      n_cmp++; if (rdmap2DdpHdrValid !== 1'b1 || rdmap2DdpControl !== 8'h00) begin n_err++; $display("FAIL send_seg%0d_v: got v=%b ctrl=%h want 1 00", s, rdmap2DdpHdrValid, rdmap2DdpControl); end
      n_cmp++; if (rdmap2DdpHeader !== exp) begin n_err++; $display("FAIL send_seg%0d_hdr: got %h want %h", s, rdmap2DdpHeader, exp); end
      n_cmp++; if (dataNumWr !== 1'b0) begin n_err++; $display("FAIL send_seg%0d_dnwr: got %b want 0", s, dataNumWr); end
      step();
    end
    n_cmp++; if (rdmap2DdpHdrValid !== 1'b0) begin n_err++; $display("FAIL send_end: got %b want 0", rdmap2DdpHdrValid); end
  endtask

  task automatic test_stall();
    logic [47:0] exp0, exp1;
    exp0 = {8'h5A, 3'd0, 1'b0, 36'h0};
    exp1 = {8'h5A, 3'd1, 1'b1, 36'h0};
    cnt[2] = 1;
    sendFifoData = {3'd2, 8'h5A};
    ddp2RdmapHdrReady = 1'b0;
    drive_fifos();
    n_cmp++; if (pops() !== 5'b00100) begin n_err++; $display("FAIL stall_pop: got %b want 00100", pops()); end
    step();
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        cnt[3] = 1;
        wrDoneFifoData = 8'hC4;
        drive_fifos();
      end
      n_cmp++; if (rdmap2DdpHdrValid !== 1'b1 || rdmap2DdpHeader !== exp0) begin n_err++; $display("FAIL stall_hold%0d: got v=%b hdr=%h want 1 %h", k, rdmap2DdpHdrValid, rdmap2DdpHeader, exp0); end
      n_cmp++; if (pops() !== 5'b0) begin n_err++; $display("FAIL stall_nopop%0d: got %b want 00000", k, pops()); end
      step();
    end
    ddp2RdmapHdrReady = 1'b1;
    step();
    n_cmp++; if (rdmap2DdpHdrValid !== 1'b1 || rdmap2DdpHeader !== exp1) begin n_err++; $display("FAIL stall_seg1: got v=%b hdr=%h want 1 %h", rdmap2DdpHdrValid, rdmap2DdpHeader, exp1); end
    ddp2RdmapHdrReady = 1'b0;
    step();
    n_cmp++; if (rdmap2DdpHdrValid !== 1'b1 || rdmap2DdpHeader !== exp1) begin n_err++; $display("FAIL stall_seg1_hold: got v=%b hdr=%h want 1 %h", rdmap2DdpHdrValid, rdmap2DdpHeader, exp1); end
    ddp2RdmapHdrReady = 1'b1;
    step();
    n_cmp++; if (rdmap2DdpHdrValid !== 1'b0) begin n_err++; $display("FAIL stall_end: got %b want 0", rdmap2DdpHdrValid); end
    n_cmp++; if (pops() !== 5'b01000) begin n_err++; $display("FAIL wrdone_pop: got %b want 01000", pops()); end
    step();
    n_cmp++; if (rdmap2DdpControl !== 8'h06 || rdmap2DdpHeader !== 48'hC40000000000) begin n_err++; $display("FAIL wrdone_hdr: got %h/%h want 06/c40000000000", rdmap2DdpControl, rdmap2DdpHeader); end
    step();
  endtask

  task automatic test_round_robin();
    int k;
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    exp_ctrl[0] = 8'h07;
    exp_ctrl[1] = 8'h03;
    exp_ctrl[2] = 8'h00;
    exp_ctrl[3] = 8'h06;
    exp_ctrl[4] = 8'h04;
    ackFifoData    = 24'h010203;
    reqFifoData    = 48'hA1B2C3D4E5F6;
    sendFifoData   = {3'd1, 8'h77};
    wrDoneFifoData = 8'h88;
    rdDoneFifoData = 8'h99;
    for (int i = 0; i < 5; i++) cnt[i] = 100;
    drive_fifos();
    for (int m = 0; m < 10; m++) begin
      k = m % 5;
      n_cmp++; if (pops() !== (5'b00001 << k)) begin n_err++; $display("FAIL rr_pop%0d: got %b want %b", m, pops(), 5'b00001 << k); end
      step();
      n_cmp++; if (rdmap2DdpHdrValid !== 1'b1 || rdmap2DdpControl !== exp_ctrl[k]) begin n_err++; $display("FAIL rr_ctrl%0d: got v=%b ctrl=%h want 1 %h", m, rdmap2DdpHdrValid, rdmap2DdpControl, exp_ctrl[k]); end
      if (k == 1) begin
        n_cmp++; if (rdmap2DdpHeader !== 48'hA1B2C3D4E5F6) begin n_err++; $display("FAIL rr_req_hdr: got %h want a1b2c3d4e5f6", rdmap2DdpHeader); end
      end
      step();
    end
    for (int i = 0; i < 5; i++) cnt[i] = 0;
    drive_fifos();
  endtask

  task automatic test_zero_datanum();
    cnt[2] = 1;
    sendFifoData = {3'd0, 8'hA7};
    drive_fifos();
    n_cmp++; if (dataNumWr !== 1'b1 || dataNumWrAddr !== 8'hA7 || dataNumWrData !== 3'd1) begin n_err++; $display("FAIL zero_dnwr: got %b/%h/%0d want 1/a7/1", dataNumWr, dataNumWrAddr, dataNumWrData); end
    n_cmp++; if (errDataNum !== 1'b1) begin n_err++; $display("FAIL zero_err: got %b want 1", errDataNum); end
    step();
    n_cmp++; if (errDataNum !== 1'b0) begin n_err++; $display("FAIL zero_err_once: got %b want 0", errDataNum); end
    n_cmp++; if (rdmap2DdpHdrValid !== 1'b1 || rdmap2DdpHeader !== 48'hA71000000000) begin n_err++; $display("FAIL zero_hdr: got v=%b hdr=%h want 1 a71000000000", rdmap2DdpHdrValid, rdmap2DdpHeader); end
    step();
    n_cmp++; if (rdmap2DdpHdrValid !== 1'b0 || errDataNum !== 1'b0) begin n_err++; $display("FAIL zero_end: got v=%b err=%b want 0 0", rdmap2DdpHdrValid, errDataNum); end
  endtask

  task automatic test_reset_mid_send();
    cnt[2] = 1;
    sendFifoData = {3'd4, 8'h22};
    drive_fifos();
    step();
    step();
    n_cmp++; if (rdmap2DdpHeader !== 48'h222000000000) begin n_err++; $display("FAIL mid_seg1: got %h want 222000000000", rdmap2DdpHeader); end
    reset = 1'b0;
    cnt[0] = 1;
    drive_fifos();
    n_cmp++; if (rdmap2DdpHdrValid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got v=%b busy=%b want 0 0", rdmap2DdpHdrValid, busy); end
    n_cmp++; if (rdmap2DdpHeader !== 48'h0 || rdmap2DdpControl !== 8'h0) begin n_err++; $display("FAIL mid_rst_hdr: got %h/%h want 0/0", rdmap2DdpHeader, rdmap2DdpControl); end
    n_cmp++; if (pops() !== 5'b0) begin n_err++; $display("FAIL mid_rst_pops: got %b want 00000", pops()); end
    step();
    cnt[0] = 0;
    drive_fifos();
    reset = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (busy !== 1'b0 || rdmap2DdpHdrValid !== 1'b0 || pops() !== 5'b0) begin n_err++; $display("FAIL mid_idle%0d: got busy=%b v=%b pops=%b want 0 0 00000", c, busy, rdmap2DdpHdrValid, pops()); end
      step();
    end
    cnt[2] = 1;
    sendFifoData = {3'd1, 8'h23};
    drive_fifos();
    n_cmp++; if (pops() !== 5'b00100) begin n_err++; $display("FAIL mid_new_pop: got %b want 00100", pops()); end
    step();
    n_cmp++; if (rdmap2DdpHeader !== 48'h231000000000) begin n_err++; $display("FAIL mid_new_hdr: got %h want 231000000000", rdmap2DdpHeader); end
    step();
    n_cmp++; if (rdmap2DdpHdrValid !== 1'b0) begin n_err++; $display("FAIL mid_new_end: got %b want 0", rdmap2DdpHdrValid); end
  endtask

  initial begin
    reset = 1'b0;
    ddp2RdmapHdrReady = 1'b1;
    sendFifoData = '0;
    ackFifoData = '0;
    wrDoneFifoData = '0;
    rdDoneFifoData = '0;
    reqFifoData = '0;
    for (int i = 0; i < 5; i++) cnt[i] = 0;
    ackFifoEmpty = 1'b1;
    reqFifoEmpty = 1'b1;
    sendFifoEmpty = 1'b1;
    wrDoneFifoEmpty = 1'b1;
    rdDoneFifoEmpty = 1'b1;
    test_reset();
    test_ack();
    test_send();
    test_stall();
    test_round_robin();
    test_zero_datanum();
    test_reset_mid_send();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
